// File: rtl/host_if_pkg.sv
// Shared types and default sizing for the host frame receiver.
package host_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_HOLD
    } state_t;

    localparam int unsigned DEF_WORD_W = 8;
    localparam int unsigned DEF_DEPTH  = 256;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous host line with edge pulses.
module sync_edge_detect #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    // Shift the async line through the chain; keep one history flop for edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_hist <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_hist;
    assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/host_frame_receiver.sv
// Captures a chip-select framed serial transaction into a word buffer and
// holds it for a downstream consumer until acknowledged.
module host_frame_receiver
    import host_if_pkg::*;
#(
    parameter int unsigned WORD_W      = DEF_WORD_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter bit          MSB_FIRST   = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              inCLK,
    input  logic              inRST,
    input  logic              inTCK,
    input  logic              inTCS,
    input  logic              inTDI,
    input  logic [ADDR_W-1:0] inRdAddr,
    output logic [WORD_W-1:0] outRdData,
    input  logic              inFrameAck,
    output logic              outFrameDone,
    output logic              outFrameValid,
    output logic [ADDR_W:0]   outWordCount,
    output logic              outOverflow,
    output logic              outPartial,
    output logic              outRejected,
    output logic              outBusy
);

    localparam int unsigned BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned SE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [BC_W-1:0]   BC_LAST     = BC_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W + 1)'(DEPTH);
    localparam logic [SE_W-1:0]   SETTLE_LAST = SE_W'(SYNC_STAGES);

    logic w_tck_rise, w_tck_fall, w_tck_lvl;
    logic w_tcs_rise, w_tcs_fall, w_tcs_lvl;
    logic w_tdi_lvl, w_tdi_rise, w_tdi_fall;
    logic w_unused_edges;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tck (
        .i_clk(inCLK), .i_rst(inRST), .i_async(inTCK),
        .o_level(w_tck_lvl), .o_rise(w_tck_rise), .o_fall(w_tck_fall)
    );
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_tcs (
        .i_clk(inCLK), .i_rst(inRST), .i_async(inTCS),
        .o_level(w_tcs_lvl), .o_rise(w_tcs_rise), .o_fall(w_tcs_fall)
    );
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tdi (
        .i_clk(inCLK), .i_rst(inRST), .i_async(inTDI),
        .o_level(w_tdi_lvl), .o_rise(w_tdi_rise), .o_fall(w_tdi_fall)
    );

    assign w_unused_edges = &{1'b0, w_tck_lvl, w_tck_fall, w_tdi_rise, w_tdi_fall};

    state_t              r_state;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [ADDR_W:0]     r_word_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic                r_done, r_valid, r_ovf, r_partial, r_rej;
    logic [SE_W-1:0]     r_settle;
    logic                r_armed;
    logic [WORD_W-1:0]   r_rd_data;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    logic [WORD_W-1:0]   w_shift_next;
    logic                w_bit_in, w_word_end, w_we;

    always_comb begin
        w_shift_next = MSB_FIRST ? {r_shift[WORD_W-2:0], w_tdi_lvl}
                                 : {w_tdi_lvl, r_shift[WORD_W-1:1]};
        // A TCS rise in the same cycle as a TCK rise closes the frame and drops the bit.
        w_bit_in   = (r_state == ST_RECV) && !w_tcs_rise && w_tck_rise && !w_tcs_lvl;
        w_word_end = w_bit_in && (r_bit_cnt == BC_LAST);
        w_we       = !inRST && w_word_end && (r_word_cnt != DEPTH_C);
    end

    // After reset the synchronised TCS only reflects the pin once the chain has
    // flushed; a frame may start only after TCS has then been seen high, so a
    // frame interrupted by reset is never joined mid-way.
    always_ff @(posedge inCLK) begin
        if (inRST) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else if (r_settle != SETTLE_LAST) begin
            r_settle <= r_settle + 1'b1;
        end else if (w_tcs_lvl) begin
            r_armed <= 1'b1;
        end
    end

    // Frame FSM: idle, receiving bits, holding a completed frame.
    always_ff @(posedge inCLK) begin
        if (inRST) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_partial  <= 1'b0;
            r_rej      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tcs_fall && r_armed) begin
                        r_state    <= ST_RECV;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_shift    <= '0;
                        r_ovf      <= 1'b0;
                        r_partial  <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (w_tcs_rise) begin
                        r_state   <= ST_HOLD;
                        r_done    <= 1'b1;
                        r_valid   <= 1'b1;
                        r_partial <= (r_bit_cnt != '0);
                    end else if (w_bit_in) begin
                        r_shift <= w_shift_next;
                        if (w_word_end) begin
                            r_bit_cnt <= '0;
                            if (r_word_cnt == DEPTH_C) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (inFrameAck) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_rej   <= 1'b0;
                    end else if (w_tcs_fall) begin
                        r_rej <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Buffer write port; contents deliberately not reset.
    always_ff @(posedge inCLK) begin
        if (w_we) begin
            r_mem[r_word_cnt[ADDR_W-1:0]] <= w_shift_next;
        end
    end

    // Registered buffer read port.
    always_ff @(posedge inCLK) begin
        if (inRST) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[inRdAddr];
        end
    end

    assign outRdData     = r_rd_data;
    assign outFrameDone  = r_done;
    assign outFrameValid = r_valid;
    assign outWordCount  = r_word_cnt;
    assign outOverflow   = r_ovf;
    assign outPartial    = r_partial;
    assign outRejected   = r_rej;
    assign outBusy       = (r_state == ST_RECV);

endmodule

// File: tb/tb_host_frame_receiver.sv
// Self-checking bench: three receiver configurations driven by a host model.
module tb_host_frame_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] h_tck = '0, h_tcs = '1, h_tdi = '0, h_ack = '0;
    logic [2:0] v_done, v_valid, v_ovf, v_part, v_rej, v_busy;
    logic [7:0]  a0 = '0, a1 = '0;
    logic [1:0]  a2 = '0;
    logic [7:0]  r0, r2;
    logic [15:0] r1;
    logic [8:0]  c0, c1;
    logic [2:0]  c2;

    host_frame_receiver #(.WORD_W(8), .DEPTH(256), .MSB_FIRST(1'b0)) u_dut0 (
        .inCLK(clk), .inRST(rst), .inTCK(h_tck[0]), .inTCS(h_tcs[0]), .inTDI(h_tdi[0]),
        .inRdAddr(a0), .outRdData(r0), .inFrameAck(h_ack[0]), .outFrameDone(v_done[0]),
        .outFrameValid(v_valid[0]), .outWordCount(c0), .outOverflow(v_ovf[0]),
        .outPartial(v_part[0]), .outRejected(v_rej[0]), .outBusy(v_busy[0])
    );
    host_frame_receiver #(.WORD_W(16), .DEPTH(256), .MSB_FIRST(1'b1)) u_dut1 (
        .inCLK(clk), .inRST(rst), .inTCK(h_tck[1]), .inTCS(h_tcs[1]), .inTDI(h_tdi[1]),
        .inRdAddr(a1), .outRdData(r1), .inFrameAck(h_ack[1]), .outFrameDone(v_done[1]),
        .outFrameValid(v_valid[1]), .outWordCount(c1), .outOverflow(v_ovf[1]),
        .outPartial(v_part[1]), .outRejected(v_rej[1]), .outBusy(v_busy[1])
    );
    host_frame_receiver #(.WORD_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_dut2 (
        .inCLK(clk), .inRST(rst), .inTCK(h_tck[2]), .inTCS(h_tcs[2]), .inTDI(h_tdi[2]),
        .inRdAddr(a2), .outRdData(r2), .inFrameAck(h_ack[2]), .outFrameDone(v_done[2]),
        .outFrameValid(v_valid[2]), .outWordCount(c2), .outOverflow(v_ovf[2]),
        .outPartial(v_part[2]), .outRejected(v_rej[2]), .outBusy(v_busy[2])
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt [3] = '{0, 0, 0};
    logic [15:0] sb_q [$];

    // Count frame-done pulses per instance.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (v_done[d]) done_cnt[d]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] cnt(input int d);
        case (d)
            0:       return c0;
            1:       return c1;
            default: return {6'b0, c2};
        endcase
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_bit(input int d, input logic b);
        h_tdi[d] = b;
        clks(3);
        h_tck[d] = 1'b1;
        clks(3);
        h_tck[d] = 1'b0;
    endtask

    task automatic host_word(input int d, input logic [15:0] v, input int n, input bit msb);
        for (int i = 0; i < n; i++) host_bit(d, msb ? v[n-1-i] : v[i]);
    endtask

    task automatic cs_low(input int d);
        h_tcs[d] = 1'b0;
        clks(3);
    endtask

    task automatic cs_high(input int d);
        clks(3);
        h_tcs[d] = 1'b1;
    endtask

    task automatic rd(input int d, input int a, output logic [15:0] v);
        case (d)
            0:       a0 = 8'(a);
            1:       a1 = 8'(a);
            default: a2 = 2'(a);
        endcase
        @(posedge clk);
        @(negedge clk);
        case (d)
            0:       v = {8'h00, r0};
            1:       v = r1;
            default: v = {8'h00, r2};
        endcase
    endtask

    // Bounded wait for the done pulse; valid must rise in the same cycle.
    task automatic wait_done(input int d, input string tag);
        bit got;
        int prev;
        got  = 1'b0;
        prev = done_cnt[d];
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (v_done[d]) begin
                got = 1'b1;
                chk({tag, "_valid_with_done"}, {31'b0, v_valid[d]}, 32'd1);
            end
        end
        chk({tag, "_done_seen"}, {31'b0, got}, 32'd1);
        clks(4);
        chk({tag, "_done_once"}, done_cnt[d], prev + 1);
    endtask

    task automatic check_frame(input int d, input int exp_cnt, input logic exp_ovf,
                               input logic exp_part, input string tag);
        logic [15:0] v;
        logic [15:0] e;
        chk({tag, "_count"},   {23'b0, cnt(d)},     exp_cnt);
        chk({tag, "_overflow"}, {31'b0, v_ovf[d]},  {31'b0, exp_ovf});
        chk({tag, "_partial"},  {31'b0, v_part[d]}, {31'b0, exp_part});
        chk({tag, "_rejected"}, {31'b0, v_rej[d]},  32'd0);
        for (int i = 0; i < exp_cnt; i++) begin
            rd(d, i, v);
            if (sb_q.size() == 0) begin
                e = 16'hDEAD;
            end else begin
                e = sb_q.pop_front();
            end
            chk($sformatf("%s_word%0d", tag, i), {16'b0, v}, {16'b0, e});
        end
        sb_q.delete();
    endtask

    task automatic ack(input int d, input string tag);
        h_ack[d] = 1'b1;
        clks(1);
        h_ack[d] = 1'b0;
        chk({tag, "_valid_after_ack"}, {31'b0, v_valid[d]}, 32'd0);
        chk({tag, "_rej_after_ack"},   {31'b0, v_rej[d]},   32'd0);
    endtask

    typedef struct {
        int         nwords;
        logic [7:0] w [4];
        int         nextra;
        logic [7:0] extra;
        int         exp_cnt;
        logic       exp_part;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [15:0] v;
        int prev;

        tbl[0].nwords = 3; tbl[0].w[0] = 8'hA5; tbl[0].w[1] = 8'h3C; tbl[0].w[2] = 8'hFF; tbl[0].w[3] = 8'h00;
        tbl[0].nextra = 0; tbl[0].extra = 8'h00; tbl[0].exp_cnt = 3; tbl[0].exp_part = 1'b0;
        tbl[1].nwords = 2; tbl[1].w[0] = 8'h12; tbl[1].w[1] = 8'h34; tbl[1].w[2] = 8'h00; tbl[1].w[3] = 8'h00;
        tbl[1].nextra = 3; tbl[1].extra = 8'h05; tbl[1].exp_cnt = 2; tbl[1].exp_part = 1'b1;
        tbl[2].nwords = 4; tbl[2].w[0] = 8'h01; tbl[2].w[1] = 8'h80; tbl[2].w[2] = 8'h00; tbl[2].w[3] = 8'h7E;
        tbl[2].nextra = 7; tbl[2].extra = 8'h7F; tbl[2].exp_cnt = 4; tbl[2].exp_part = 1'b1;
        tbl[3].nwords = 0; tbl[3].w[0] = 8'h00; tbl[3].w[1] = 8'h00; tbl[3].w[2] = 8'h00; tbl[3].w[3] = 8'h00;
        tbl[3].nextra = 0; tbl[3].extra = 8'h00; tbl[3].exp_cnt = 0; tbl[3].exp_part = 1'b0;

        // Reset state.
        clks(3);
        chk("rst_busy",  {29'b0, v_busy},  32'd0);
        chk("rst_valid", {29'b0, v_valid}, 32'd0);
        chk("rst_done",  {29'b0, v_done},  32'd0);
        chk("rst_count", {23'b0, c0},      32'd0);
        chk("rst_flags", {20'b0, v_ovf, v_part, v_rej, 3'b0}, 32'd0);
        rst = 1'b0;
        clks(6);

        // Table-driven frames on the LSB-first 8-bit instance.
        for (int t = 0; t < 4; t++) begin
            cs_low(0);
            chk($sformatf("t%0d_busy", t), {31'b0, v_busy[0]}, 32'd1);
            for (int i = 0; i < tbl[t].nwords; i++) begin
                sb_q.push_back({8'h00, tbl[t].w[i]});
                host_word(0, {8'h00, tbl[t].w[i]}, 8, 1'b0);
            end
            host_word(0, {8'h00, tbl[t].extra}, tbl[t].nextra, 1'b0);
            cs_high(0);
            wait_done(0, $sformatf("t%0d", t));
            chk($sformatf("t%0d_idle_busy", t), {31'b0, v_busy[0]}, 32'd0);
            check_frame(0, tbl[t].exp_cnt, 1'b0, tbl[t].exp_part, $sformatf("t%0d", t));
            ack(0, $sformatf("t%0d", t));
        end

        // Ack outside HOLD is ignored.
        h_ack[0] = 1'b1;
        clks(2);
        h_ack[0] = 1'b0;
        chk("idle_ack_valid", {31'b0, v_valid[0]}, 32'd0);
        chk("idle_ack_busy",  {31'b0, v_busy[0]},  32'd0);

        // MSB-first 16-bit word.
        cs_low(1);
        sb_q.push_back(16'h1234);
        host_word(1, 16'h1234, 16, 1'b1);
        cs_high(1);
        wait_done(1, "msb16");
        check_frame(1, 1, 1'b0, 1'b0, "msb16");
        ack(1, "msb16");

        // Overflow on the depth-4 instance: only the first four bytes stored.
        cs_low(2);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb_q.push_back(16'((i + 1) * 8'h11));
            host_word(2, 16'((i + 1) * 8'h11), 8, 1'b0);
        end
        cs_high(2);
        wait_done(2, "ovf");
        check_frame(2, 4, 1'b1, 1'b0, "ovf");
        ack(2, "ovf");

        // Frame arriving while one is held is rejected and leaves the buffer alone.
        cs_low(0);
        host_word(0, 16'h00C3, 8, 1'b0);
        cs_high(0);
        wait_done(0, "hold1");
        prev = done_cnt[0];
        cs_low(0);
        chk("rej_flag", {31'b0, v_rej[0]}, 32'd1);
        host_word(0, 16'h0099, 8, 1'b0);
        host_word(0, 16'h0077, 8, 1'b0);
        cs_high(0);
        clks(10);
        chk("rej_no_done", done_cnt[0], prev);
        chk("rej_valid",   {31'b0, v_valid[0]}, 32'd1);
        chk("rej_count",   {23'b0, c0}, 32'd1);
        rd(0, 0, v);
        chk("rej_buf0",    {16'b0, v}, 32'h0000_00C3);
        ack(0, "rej");
        cs_low(0);
        sb_q.push_back(16'h0055);
        host_word(0, 16'h0055, 8, 1'b0);
        cs_high(0);
        wait_done(0, "after_rej");
        check_frame(0, 1, 1'b0, 1'b0, "after_rej");
        ack(0, "after_rej");

        // Reset mid-frame after 5 bits; the resumed frame must not be joined.
        cs_low(0);
        host_word(0, 16'h0015, 5, 1'b0);
        chk("mid_busy_before", {31'b0, v_busy[0]}, 32'd1);
        rst = 1'b1;
        clks(2);
        chk("mid_rst_busy",  {31'b0, v_busy[0]},  32'd0);
        chk("mid_rst_count", {23'b0, c0},         32'd0);
        chk("mid_rst_flags", {28'b0, v_valid[0], v_ovf[0], v_part[0], v_rej[0]}, 32'd0);
        chk("mid_rst_rdata", {24'b0, r0},         32'd0);
        rst = 1'b0;
        prev = done_cnt[0];
        host_word(0, 16'h0007, 3, 1'b0);
        host_word(0, 16'h00AA, 8, 1'b0);
        chk("mid_resume_busy", {31'b0, v_busy[0]}, 32'd0);
        cs_high(0);
        clks(12);
        chk("mid_resume_no_done", done_cnt[0], prev);
        chk("mid_resume_count",   {23'b0, c0}, 32'd0);

        // A proper frame after the interrupted one is received normally.
        cs_low(0);
        sb_q.push_back(16'h0081);
        host_word(0, 16'h0081, 8, 1'b0);
        cs_high(0);
        wait_done(0, "post_rst");
        check_frame(0, 1, 1'b0, 1'b0, "post_rst");
        ack(0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/host_frame_receiver.md
# host_frame_receiver

Parametrised successor to the host serial byte receiver: captures a complete chip-select-framed serial transaction (inTCK/inTCS/inTDI) into an addressable word buffer, all logic running on one system clock. The host lines are treated as asynchronous data, synchronised and edge-detected internally. The block adds word-width, buffer-depth and bit-order parameters, plus a frame handshake with word count and overflow/reject flags for the downstream CNN loader.

## Interface
- WORD_W, 8, bits per word shifted in per group of TCK edges
- DEPTH, 256, buffer depth in words
- ADDR_W, $clog2(DEPTH), read address width
- MSB_FIRST, 0, 0 = first bit lands in word bit 0 (LSB first); 1 = first bit lands in bit WORD_W-1
- SYNC_STAGES, 2, synchroniser flops on each host line (≥2)

- inCLK  in  1  system clock, all state on rising edge
- inRST  in  1  synchronous, active-high reset
- inTCK  in  1  host serial clock (async), data sampled on its rising edge
- inTCS  in  1  host chip select (async), active low
- inTDI  in  1  host serial data (async)
- inRdAddr  in  ADDR_W  buffer read address
- outRdData  out  WORD_W  registered buffer word at inRdAddr
- inFrameAck  in  1  consumer releases the held frame
- outFrameDone  out  1  one-cycle pulse when a frame closes
- outFrameValid  out  1  held frame available
- outWordCount  out  ADDR_W+1  complete words stored in current/held frame
- outOverflow  out  1  sticky: words arrived beyond DEPTH
- outPartial  out  1  sticky: frame closed with 1..WORD_W-1 leftover bits
- outRejected  out  1  sticky: host started a frame while one was held
- outBusy  out  1  state == RECV

## Operation
- Sync: each host line through SYNC_STAGES flops, plus one history flop for TCK/TCS edge detection. Reset values: TCS=1, TCK=0, TDI=0 (no false edges out of reset).
- States: IDLE, RECV, HOLD.
- IDLE: on synced TCS falling edge -> RECV; clear bit_cnt, word_cnt, shift reg, outOverflow, outPartial.
- RECV: on synced TCK rising edge with synced TCS low, shift TDI in per MSB_FIRST; bit_cnt++. At bit_cnt == WORD_W-1 the completed word is written to buffer[word_cnt], word_cnt++, bit_cnt=0. If word_cnt == DEPTH, the word is discarded and outOverflow set; word_cnt saturates at DEPTH.
- RECV: on synced TCS rising edge -> HOLD; outFrameDone pulses; outFrameValid=1; outPartial=1 if bit_cnt≠0 (leftover bits dropped).
- Simultaneous TCK rise and TCS rise in the same cycle: the TCS rise wins and the bit is dropped.
- HOLD: host activity does not touch the buffer. A TCS falling edge sets outRejected and the frame is ignored. inFrameAck -> IDLE; clears outFrameValid and outRejected. outWordCount holds until the next frame starts.
- After an ack with TCS still low (a rejected frame in progress), the block waits in IDLE for the next TCS falling edge; it never joins a frame mid-way.
- inFrameAck outside HOLD: ignored.
- inRST at any point: state IDLE, all counters, flags and outputs 0, shift reg 0. Buffer contents are undefined/not cleared.

## Timing
- Host TCK high and low phases each ≥ 2 inCLK periods; TCS setup/hold to TCK edges ≥ 2 inCLK periods.
- TCK edge at pin -> word write: SYNC_STAGES+1 cycles. TCS rise -> outFrameDone: SYNC_STAGES+1 cycles.
- Read port: outRdData valid 1 cycle after inRdAddr. A word written in cycle N is readable by an address presented in cycle N+1.
- outFrameValid rises in the same cycle as outFrameDone and falls 1 cycle after inFrameAck is sampled.

## Structure
- Package host_if_pkg: state enum (IDLE/RECV/HOLD), default WORD_W/DEPTH constants.
- Sub-module sync_edge_detect: parametrised synchroniser with rise/fall pulses, one instance per host line (TDI uses the level output only).
- Buffer inferred as simple dual-port RAM in the top level. Total size 150–300 lines.

## Test plan
- Reset then a 3-byte frame 0xA5,0x3C,0xFF, LSB-first -> outFrameDone once; outWordCount=3; addresses 0..2 read 0xA5,0x3C,0xFF; all flags 0.
- MSB_FIRST=1, WORD_W=16, host shifts 0x1234 MSB first -> buffer[0]=0x1234; outWordCount=1.
- DEPTH=4, frame of 6 bytes -> outWordCount=4; outOverflow=1; buffer[0..3] holds bytes 0..3.
- Frame of 2 bytes + 3 bits -> outWordCount=2; outPartial=1.
- Second frame sent while HOLD, no ack -> outRejected=1 and buffer unchanged. After ack and a new frame 0x55 -> buffer[0]=0x55; outRejected=0.
- inRST asserted mid-frame after 5 bits -> outputs 0, state IDLE. Frame resumed without a new TCS fall -> no write.
